// File: rtl/led_effect_sequencer_pkg.sv
// Shared types, constants and colour helpers for the RGB LED effect sequencer.
// Holds the mode enum, phase/level limits and the rainbow triangle-clamp function.
package led_pkg;

    typedef enum logic [1:0] {
        RAINBOW = 2'd0,
        BREATHE = 2'd1,
        BLINK   = 2'd2,
        OFF     = 2'd3
    } led_mode_e;

    localparam logic [10:0] PHASE_MAX   = 11'd1535;
    localparam logic [10:0] PHASE_G_OFS = 11'd512;
    localparam logic [10:0] PHASE_B_OFS = 11'd1024;
    localparam logic [7:0]  LEVEL_MAX   = 8'd255;

    // Offset a rainbow phase, wrapping inside 0..PHASE_MAX.
    function automatic logic [10:0] phase_add(
        input logic [10:0] p,
        input logic [10:0] ofs
    );
        logic [11:0] s;
        s = {1'b0, p} + {1'b0, ofs};
        if (s > {1'b0, PHASE_MAX})
            s = s - 12'd1536;
        return s[10:0];
    endfunction

    // Triangle peaking at phase 512, clipped to 0..255.
    function automatic logic [7:0] tri_clamp(input logic [10:0] p);
        logic signed [11:0] d;
        d = 12'sd512 - $signed({1'b0, p});
        if (d < 12'sd0)
            d = -d;
        d = 12'sd512 - d;
        if (d < 12'sd0)
            return 8'd0;
        if (d > 12'sd255)
            return LEVEL_MAX;
        return d[7:0];
    endfunction

endpackage

// File: rtl/led_effect_sequencer_if.sv
// Colour/mode output bundle from the effect sequencer to the PWM stage.
// master drives oR/oG/oB/oMODE/oTICK, slave (PWM stage or monitor) observes.
interface led_effect_sequencer_if;

    logic [7:0] oR;
    logic [7:0] oG;
    logic [7:0] oB;
    logic [1:0] oMODE;
    logic       oTICK;

    modport master (
        output oR, oG, oB, oMODE, oTICK
    );

    modport slave (
        input oR, oG, oB, oMODE, oTICK
    );

endinterface

// File: rtl/led_effect_sequencer_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, press pulse.
// Ports: iCLOCK, iRESET_n, iBUTTON_n (raw, active-low) -> oPRESS (1-cycle on press).
module button_debouncer #(
    parameter int DEBOUNCE = 120000
) (
    input  logic iCLOCK,
    input  logic iRESET_n,
    input  logic iBUTTON_n,
    output logic oPRESS
);

    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            oPRESS <= 1'b0;
        end else begin
            sync1  <= iBUTTON_n;
            sync2  <= sync1;
            oPRESS <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level  <= sync2;
                cnt    <= '0;
                // only the falling (pressed) transition is reported
                oPRESS <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_effect_sequencer.sv
// RGB LED mode controller: button cycles RAINBOW/BREATHE/BLINK/OFF effects.
// Ports: iCLOCK, iRESET_n, iBUTTON_n; bus.master carries oR/oG/oB/oMODE/oTICK.
module led_effect_sequencer
    import led_pkg::*;
#(
    parameter int TICK_DIV = 240000,
    parameter int DEBOUNCE = 120000
) (
    input  logic                          iCLOCK,
    input  logic                          iRESET_n,
    input  logic                          iBUTTON_n,
    led_effect_sequencer_if.master        bus
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic          press;
    led_mode_e     mode;
    logic [TW-1:0] tickCnt;
    logic          tick;
    logic [10:0]   phase;
    logic [7:0]    level;
    logic          levelUp;
    logic [6:0]    blinkCnt;
    logic [7:0]    colR;
    logic [7:0]    colG;
    logic [7:0]    colB;
    logic [7:0]    outR;
    logic [7:0]    outG;
    logic [7:0]    outB;

    button_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debouncer (
        .iCLOCK    (iCLOCK),
        .iRESET_n  (iRESET_n),
        .iBUTTON_n (iBUTTON_n),
        .oPRESS    (press)
    );

    assign tick = (tickCnt == TICK_LAST);

    // Mode FSM and effect state; a press restarts everything and
    // swallows a tick landing on the same edge.
    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            mode     <= RAINBOW;
            tickCnt  <= '0;
            phase    <= '0;
            level    <= '0;
            levelUp  <= 1'b1;
            blinkCnt <= '0;
        end else if (press) begin
            mode     <= led_mode_e'(mode + 2'd1);
            tickCnt  <= '0;
            phase    <= '0;
            level    <= '0;
            levelUp  <= 1'b1;
            blinkCnt <= '0;
        end else begin
            tickCnt <= tick ? '0 : tickCnt + 1'b1;
            if (tick) begin
                unique case (mode)
                    RAINBOW: begin
                        phase <= (phase == PHASE_MAX) ? 11'd0 : phase + 11'd1;
                    end
                    BREATHE: begin
                        if (levelUp) begin
                            level <= level + 8'd1;
                            if (level == 8'(LEVEL_MAX - 8'd1))
                                levelUp <= 1'b0;
                        end else begin
                            level <= level - 8'd1;
                            if (level == 8'd1)
                                levelUp <= 1'b1;
                        end
                    end
                    BLINK: begin
                        blinkCnt <= blinkCnt + 7'd1;
                    end
                    OFF: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        colR = 8'd0;
        colG = 8'd0;
        colB = 8'd0;
        unique case (mode)
            RAINBOW: begin
                colR = tri_clamp(phase);
                colG = tri_clamp(phase_add(phase, PHASE_G_OFS));
                colB = tri_clamp(phase_add(phase, PHASE_B_OFS));
            end
            BREATHE: begin
                colR = level;
                colG = level;
                colB = level;
            end
            BLINK: begin
                colR = blinkCnt[6] ? 8'd0 : LEVEL_MAX;
                colG = blinkCnt[6] ? 8'd0 : LEVEL_MAX;
                colB = blinkCnt[6] ? 8'd0 : LEVEL_MAX;
            end
            OFF: begin
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            outR <= 8'd0;
            outG <= 8'd0;
            outB <= 8'd0;
        end else begin
            outR <= colR;
            outG <= colG;
            outB <= colB;
        end
    end

    assign bus.oR    = outR;
    assign bus.oG    = outG;
    assign bus.oB    = outB;
    assign bus.oMODE = mode;
    assign bus.oTICK = tick;

endmodule

// File: tb/tb_led_effect_sequencer.sv
// Scoreboard bench for led_effect_sequencer with TICK_DIV = DEBOUNCE = 4.
// Stimulus queues expected mode changes; a negedge monitor checks every output.
module tb_led_effect_sequencer;

    localparam int TD = 4;
    localparam int DB = 4;

    typedef struct {
        int at;
        int mode;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic button_n = 1'b1;
    int   edgeNo = 0;
    int   nChecks = 0;
    int   nPass = 0;
    ev_t  q[$];
    int   sMode = 0;
    int   sEntry = 0;
    int   mMode = 0;
    int   mEntry = 0;

    led_effect_sequencer_if bus();

    led_effect_sequencer #(
        .TICK_DIV (TD),
        .DEBOUNCE (DB)
    ) dut (
        .iCLOCK    (clk),
        .iRESET_n  (rst_n),
        .iBUTTON_n (button_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n)
            edgeNo <= 0;
        else
            edgeNo <= edgeNo + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp)
            nPass++;
        else
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, edgeNo);
    endtask

    function automatic int triV(input int p);
        int d;
        int v;
        d = (p > 512) ? p - 512 : 512 - p;
        v = 512 - d;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    // Colour expected after k effect steps in a given mode.
    function automatic int expRGB(input int mode, input int k);
        int p;
        int t;
        int l;
        case (mode)
            0: begin
                p = k % 1536;
                return (triV(p) << 16) | (triV((p + 512) % 1536) << 8)
                       | triV((p + 1024) % 1536);
            end
            1: begin
                t = k % 510;
                l = (t <= 255) ? t : 510 - t;
                return (l << 16) | (l << 8) | l;
            end
            2: return ((k % 128) < 64) ? 32'hFFFFFF : 0;
            default: return 0;
        endcase
    endfunction

    // Monitor: state seen after edge m-1 drives the colours after edge m.
    initial begin
        int m;
        int sMd;
        int sEn;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_out",
                    int'({bus.oR, bus.oG, bus.oB, bus.oMODE, bus.oTICK}), 0);
                mMode = 0;
                mEntry = 0;
                q.delete();
            end else begin
                m = edgeNo;
                sMd = mMode;
                sEn = mEntry;
                while (q.size() > 0 && q[0].at == m) begin
                    mMode = q[0].mode;
                    mEntry = m;
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].at < m) begin
                    chk("mode_late", m, q[0].at);
                    void'(q.pop_front());
                end
                chk("mode", int'(bus.oMODE), mMode);
                chk("rgb", int'({bus.oR, bus.oG, bus.oB}),
                    expRGB(sMd, (m - 1 - sEn) / TD));
                chk("tick", int'(bus.oTICK),
                    int'(((m - mEntry) % TD) == TD - 1));
            end
        end
    end

    task automatic press(input int lowLen, input int gap, input bit aligned);
        int e;
        @(posedge clk);
        #1;
        if (aligned) begin
            for (int i = 0; i < TD; i++) begin
                if (((edgeNo + DB + 3 - sEntry) % TD) == 0) break;
                @(posedge clk);
                #1;
            end
        end
        e = edgeNo;
        button_n = 1'b0;
        sMode = (sMode + 1) % 4;
        sEntry = e + DB + 3;
        q.push_back('{at: sEntry, mode: sMode});
        repeat (lowLen) @(posedge clk);
        #1 button_n = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic glitch(input int lowLen, input int gap);
        @(posedge clk);
        #1 button_n = 1'b0;
        repeat (lowLen) @(posedge clk);
        #1 button_n = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        repeat (6200) @(posedge clk);
        press(6, 1100, 1'b0);
        press(7, 600, 1'b0);
        glitch(3, 20);
        glitch(1, 20);
        press(8, 40, 1'b0);
        press(6, 40, 1'b0);
        press(6, 100, 1'b1);
        press(6, 300, 1'b1);

        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 2) == 0)
                glitch($urandom_range(1, 3), $urandom_range(10, 40));
            else
                press($urandom_range(6, 12), $urandom_range(10, 400),
                      1'($urandom_range(0, 1)));
        end

        while (sMode != 1)
            press(7, 12, 1'b0);
        repeat (30) @(posedge clk);
        @(posedge clk);
        #1 button_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset",
               int'({bus.oR, bus.oG, bus.oB, bus.oMODE, bus.oTICK}), 0);
        button_n = 1'b1;
        sMode = 0;
        sEntry = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (100) @(posedge clk);

        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/led_effect_sequencer.md
# led_effect_sequencer

Mode controller for the on-board RGB LED. It generates 8-bit R/G/B intensity targets for the existing PWM output stage, which is unchanged and fed directly from this block. A debounced push-button selects one of four effects: rainbow, breathe, blink and off. All effect timing derives from one programmable step tick.

## Interface
- TICK_DIV, 240000: clocks per effect step; legal range ≥2.
- DEBOUNCE, 120000: stable-sample count required to accept a button level; legal range ≥2.
- iCLOCK  in  1  system clock; single clock domain.
- iRESET_n  in  1  asynchronous, active-low reset.
- iBUTTON_n  in  1  raw mode button, active-low, asynchronous to iCLOCK.
- oR, oG, oB  out  8 each  registered intensity targets to the PWM stage; 255 = full on.
- oMODE  out  2  current effect: 0 RAINBOW, 1 BREATHE, 2 BLINK, 3 OFF.
- oTICK  out  1  one-cycle strobe on each effect step.

## Operation
- **Button path**
  - iBUTTON_n passes through a 2-flop synchronizer; both flops reset to 1.
  - Debounced level resets to 1 (released).
  - Counter behaviour while synced ≠ debounced: increments each cycle.
  - Counter behaviour while synced = debounced: clears to 0.
  - At counter == DEBOUNCE-1 with levels still differing: debounced level takes the synced value and the counter clears.
  - A 1→0 debounced transition raises a registered one-cycle press pulse. Release generates nothing.
- **Mode FSM**
  - States: RAINBOW → BREATHE → BLINK → OFF → RAINBOW, advancing one state per press pulse.
  - Reset state: RAINBOW.
- **Step tick**
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - oTICK = 1 in the cycle the counter equals TICK_DIV-1.
- **Mode entry.** On any mode change:
  - tick counter ← 0;
  - phase ← 0;
  - breathe level ← 0, direction up;
  - blink count ← 0.
  - A tick in the same cycle as a press pulse is discarded; the mode change wins.
- **RAINBOW**
  - 11-bit phase p runs 0..1535 and wraps 1535 → 0, advancing 1 per tick.
  - Channel phases: pR = p, pG = (p+512) mod 1536, pB = (p+1024) mod 1536.
  - Channel value = clamp(512 − |512 − pX|, 0, 255). Compute in signed 12 bits.
- **BREATHE**
  - 8-bit level; oR = oG = oB = level.
  - Per tick while going up: +1; at 255 the direction flips to down.
  - Per tick while going down: −1; at 0 the direction flips to up.
  - Sequence: 0, 1, …, 255, 254, …, 0, 1, …. Each endpoint is shown for exactly one tick.
- **BLINK**
  - 7-bit count, +1 per tick, wraps.
  - Outputs are 255/255/255 while count[6] = 0, otherwise 0/0/0 (64 ticks on, 64 off).
- **OFF**
  - Outputs 0/0/0.
  - The tick keeps running; oTICK still pulses.

## Timing
- **Reset values:** oR = oG = oB = 0, oMODE = 0, oTICK = 0, all counters 0.
- **First cycle after reset release:** oR/oG/oB = 0/255/0, the rainbow value for phase 0.
- **Output latency:** oR/oG/oB are registered from the effect state, one cycle behind it. A tick at edge N updates the state at N; the outputs show the new value after edge N+1.
- **oMODE:** registered from the FSM state; it changes on the same edge as the FSM.
- **Button latency:** number edges from the one that first captures the low level into sync flop 1 as edge 0.
  - Debounced level falls at edge DEBOUNCE+1.
  - oMODE changes at edge DEBOUNCE+2.
  - Colour outputs reflect the new mode one edge later.
- **Glitches:** a low pulse shorter than DEBOUNCE synchronized cycles causes no mode change.
- **Reset mid-operation:** asynchronous. All state returns to the reset values immediately, including when the debounce is partway through.

## Structure
- **Package led_pkg** holds:
  - the mode enum, typedef led_mode_e with values RAINBOW, BREATHE, BLINK, OFF;
  - constants PHASE_MAX = 1535, PHASE_G_OFS = 512, PHASE_B_OFS = 1024, LEVEL_MAX = 255;
  - function tri_clamp, which maps an 11-bit phase to an 8-bit intensity.
- **Sub-module button_debouncer**, parameter DEBOUNCE. It contains the synchronizer, the counter and the press pulse. It is reusable for the board's other keys.

## Test plan
Bench parameters: TICK_DIV = 4, DEBOUNCE = 4.
1. Reset, then release → oR/oG/oB = 0/255/0 next cycle. After 256 ticks: 0/255/0 → 256/255 clamps; at p=256 the outputs are 255/255/0. Phase wraps to 0 after 1536 ticks.
2. Clean button low from edge 0 → oMODE 0→1 at edge 6; outputs 0/0/0 at edge 7; breathe reaches 255 after 255 ticks and reads 254 on the next tick.
3. Button low for 3 synchronized cycles, then high → no oMODE change and no press pulse.
4. Four clean presses → oMODE sequence 1, 2, 3, 0. In BLINK, outputs stay at 255 for 64 ticks, then 0 for 64 ticks.
5. Press pulse coincident with a tick edge → mode advances, the tick counter reads 0 next cycle, and the new effect starts from its initial state with no extra step.
6. iRESET_n asserted mid-BREATHE with a debounce in progress → all outputs 0 and oMODE = 0 immediately. After release, RAINBOW restarts at phase 0.
